// File: rtl/conversor_bcd_parametrizado_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
// Optional signed-input mode is selected by CONVERSOR_BCD_SINAL_EN (see conversor_bcd_parametrizado.sv).
package pacote_conversor_bcd;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONVERTE  = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  typedef logic [3:0] digito_bcd_t;

  localparam digito_bcd_t AJUSTE = 4'd3;
  localparam digito_bcd_t LIMIAR = 4'd4;

  // One digit of the saturated result; the top replicates it across all digits.
  function automatic digito_bcd_t padrao_saturacao();
    return digito_bcd_t'(4'd9);
  endfunction

endpackage

// File: rtl/conversor_bcd_parametrizado_if.sv
// Operand/result bus of the BCD converter. Both sides use valid/ready: a beat transfers on the
// rising edge where valid & ready are both high; valid never drops and data never changes until then.
interface conversor_bcd_parametrizado_if #(
  parameter int LARGURA_ENTRADA  = 16,
  parameter int DIGITOS_DECIMAIS = 5
);
  logic [LARGURA_ENTRADA-1:0]    entrada_binaria;
  logic                          entrada_valida;
  logic                          entrada_pronta;
  logic [4*DIGITOS_DECIMAIS-1:0] saida_bcd;
  logic                          saida_negativa;
  logic                          saida_estouro;
  logic [DIGITOS_DECIMAIS-1:0]   digito_ativo;
  logic                          saida_valida;
  logic                          saida_pronta;

  modport slave (
    input  entrada_binaria, entrada_valida, saida_pronta,
    output entrada_pronta, saida_bcd, saida_negativa, saida_estouro, digito_ativo, saida_valida
  );

  modport master (
    output entrada_binaria, entrada_valida, saida_pronta,
    input  entrada_pronta, saida_bcd, saida_negativa, saida_estouro, digito_ativo, saida_valida
  );
endinterface

// File: rtl/conversor_bcd_parametrizado_celula_soma3.sv
// Double-dabble correction cell: a BCD digit above 4 gets +3 before the next left shift.
module celula_soma3
  import pacote_conversor_bcd::*;
(
  input  digito_bcd_t i_digito,
  output digito_bcd_t o_digito
);
  assign o_digito = (i_digito > LIMIAR) ? digito_bcd_t'(i_digito + AJUSTE) : i_digito;
endmodule

// File: rtl/conversor_bcd_parametrizado.sv
// Sequential binary-to-BCD converter, one operand bit per clock, saturating at 10^D.
// Define CONVERSOR_BCD_SINAL_EN to treat the operand as two's complement.
module conversor_bcd_parametrizado
  import pacote_conversor_bcd::*;
#(
  parameter int LARGURA_ENTRADA  = 16,
  parameter int DIGITOS_DECIMAIS = 5
) (
  input  logic    clk,
  input  logic    reset_n,
  conversor_bcd_parametrizado_if.slave bus,
  output estado_t o_estado
);
  localparam int W  = LARGURA_ENTRADA;
  localparam int D  = DIGITOS_DECIMAIS;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(W - 1);

  estado_t        r_estado, w_prox;
  logic [W-1:0]   r_bin;
  logic [4*D-1:0] r_bcd;
  logic [CW-1:0]  r_cont;
  logic           r_estouro;
  logic [W-1:0]   w_magnitude;
  logic [4*D-1:0] w_ajustado;
  logic [4*D-1:0] w_saturado;
  logic [4*D-1:0] w_saida;
  logic [D-1:0]   w_ativo;
  logic           w_acc;
  logic           w_aceita;

  genvar g;
  generate
    for (g = 0; g < D; g++) begin : g_digito
      celula_soma3 u_celula (
        .i_digito (r_bcd[4*g +: 4]),
        .o_digito (w_ajustado[4*g +: 4])
      );
      assign w_saturado[4*g +: 4] = padrao_saturacao();
    end
  endgenerate

  assign w_aceita = (r_estado == OCIOSO) && bus.entrada_valida;

`ifdef CONVERSOR_BCD_SINAL_EN
  logic r_negativa;
  // Unsigned W-bit negate keeps -2^(W-1) exact as its own magnitude.
  assign w_magnitude = bus.entrada_binaria[W-1] ? (~bus.entrada_binaria + W'(1))
                                                 : bus.entrada_binaria;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_negativa <= 1'b0;
    else if (w_aceita) r_negativa <= bus.entrada_binaria[W-1];
  end
  assign bus.saida_negativa = r_negativa;
`else
  assign w_magnitude        = bus.entrada_binaria;
  assign bus.saida_negativa = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_estado <= OCIOSO;
    else          r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:    if (bus.entrada_valida)   w_prox = CONVERTE;
      CONVERTE:  if (r_cont == ULTIMO)     w_prox = CONCLUIDO;
      CONCLUIDO: if (bus.saida_pronta)     w_prox = OCIOSO;
      default:                             w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cont    <= '0;
      r_estouro <= 1'b0;
    end else if (w_aceita) begin
      r_bin     <= w_magnitude;
      r_bcd     <= '0;
      r_cont    <= '0;
      r_estouro <= 1'b0;
    end else if (r_estado == CONVERTE) begin
      // No guard digit: a 1 leaving the top digit means the value needs more than D digits.
      r_bin     <= {r_bin[W-2:0], 1'b0};
      r_bcd     <= {w_ajustado[4*D-2:0], r_bin[W-1]};
      r_cont    <= r_cont + CW'(1);
      r_estouro <= r_estouro | w_ajustado[4*D-1];
    end
  end

  assign w_saida = r_estouro ? w_saturado : r_bcd;

  always_comb begin
    w_ativo = '0;
    w_acc   = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      w_acc      = w_acc | (w_saida[4*i +: 4] != 4'd0);
      w_ativo[i] = w_acc;
    end
    w_ativo[0] = 1'b1;
  end

  assign bus.entrada_pronta = (r_estado == OCIOSO);
  assign bus.saida_valida   = (r_estado == CONCLUIDO);
  assign bus.saida_bcd      = w_saida;
  assign bus.saida_estouro  = r_estouro;
  assign bus.digito_ativo   = w_ativo;
  assign o_estado           = r_estado;
endmodule

// File: tb/tb_conversor_bcd_parametrizado.sv
// Directed bench for conversor_bcd_parametrizado: a 5-digit and a 4-digit instance fed the same operands.
module tb_conversor_bcd_parametrizado;
  import pacote_conversor_bcd::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  conversor_bcd_parametrizado_if #(.LARGURA_ENTRADA(W), .DIGITOS_DECIMAIS(5)) if5 ();
  conversor_bcd_parametrizado_if #(.LARGURA_ENTRADA(W), .DIGITOS_DECIMAIS(4)) if4 ();
  estado_t dbg5, dbg4;

  conversor_bcd_parametrizado #(.LARGURA_ENTRADA(W), .DIGITOS_DECIMAIS(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .bus(if5), .o_estado(dbg5)
  );
  conversor_bcd_parametrizado #(.LARGURA_ENTRADA(W), .DIGITOS_DECIMAIS(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4), .o_estado(dbg4)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [W-1:0] v, input logic rdy);
    if5.entrada_valida  = vld; if4.entrada_valida  = vld;
    if5.entrada_binaria = v;   if4.entrada_binaria = v;
    if5.saida_pronta    = rdy; if4.saida_pronta    = rdy;
  endtask

  task automatic transfere();
    drive(1'b0, '0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b0);
    chk("valida_apos_transf", {if5.saida_valida, if4.saida_valida}, 2'b00);
    chk("pronta_apos_transf", {if5.entrada_pronta, if4.entrada_pronta}, 2'b11);
  endtask

  task automatic converte(input logic [W-1:0] v,
                          input logic [19:0] e5, input logic [4:0] a5, input logic ov5,
                          input logic [15:0] e4, input logic [3:0] a4, input logic ov4,
                          input logic neg, input logic liberar);
    logic cedo;
    @(negedge clk);
    chk("pronta_antes", {if5.entrada_pronta, if4.entrada_pronta}, 2'b11);
    drive(1'b1, v, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b0);
    chk("pronta_ocupado", {if5.entrada_pronta, if4.entrada_pronta}, 2'b00);
    cedo = 1'b0;
    repeat (W - 1) begin
      @(posedge clk); #1;
      cedo = cedo | if5.saida_valida | if4.saida_valida;
    end
    chk("valida_cedo", cedo, 1'b0);
    @(posedge clk); #1;
    chk("valida_latencia_W", {if5.saida_valida, if4.saida_valida}, 2'b11);
    chk("bcd5", if5.saida_bcd, e5);
    chk("ativo5", if5.digito_ativo, a5);
    chk("estouro5", if5.saida_estouro, ov5);
    chk("bcd4", if4.saida_bcd, e4);
    chk("ativo4", if4.digito_ativo, a4);
    chk("estouro4", if4.saida_estouro, ov4);
    chk("negativa", {if5.saida_negativa, if4.saida_negativa}, {neg, neg});
    if (liberar) transfere();
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    #12;
    chk("rst_pronta", {if5.entrada_pronta, if4.entrada_pronta}, 2'b11);
    chk("rst_valida", {if5.saida_valida, if4.saida_valida}, 2'b00);
    chk("rst_bcd5", if5.saida_bcd, 20'h0);
    chk("rst_flags", {if5.saida_negativa, if5.saida_estouro, if4.saida_estouro}, 3'b000);
    chk("rst_ativo", {if5.digito_ativo, if4.digito_ativo}, {5'b00001, 4'b0001});
    chk("rst_estado", {dbg5, dbg4}, {OCIOSO, OCIOSO});
    @(negedge clk); reset_n = 1'b1;

    converte(16'd0,     20'h00000, 5'b00001, 1'b0, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b1);
`ifdef CONVERSOR_BCD_SINAL_EN
    converte(16'h8000,  20'h32768, 5'b11111, 1'b0, 16'h9999, 4'b1111, 1'b1, 1'b1, 1'b1);
    converte(16'hFFFF,  20'h00001, 5'b00001, 1'b0, 16'h0001, 4'b0001, 1'b0, 1'b1, 1'b1);
    converte(16'h7FFF,  20'h32767, 5'b11111, 1'b0, 16'h9999, 4'b1111, 1'b1, 1'b0, 1'b1);
`else
    converte(16'd65535, 20'h65535, 5'b11111, 1'b0, 16'h9999, 4'b1111, 1'b1, 1'b0, 1'b1);
    converte(16'd12345, 20'h12345, 5'b11111, 1'b0, 16'h9999, 4'b1111, 1'b1, 1'b0, 1'b1);
    converte(16'd10000, 20'h10000, 5'b11111, 1'b0, 16'h9999, 4'b1111, 1'b1, 1'b0, 1'b1);
`endif
    converte(16'd9999,  20'h09999, 5'b01111, 1'b0, 16'h9999, 4'b1111, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held while a second operand is offered and must be dropped.
    converte(16'd907,   20'h00907, 5'b00111, 1'b0, 16'h0907, 4'b0111, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(c[0], 16'd5, 1'b0);
      @(posedge clk); #1;
      chk("bp_valida", {if5.saida_valida, if4.saida_valida}, 2'b11);
      chk("bp_pronta", {if5.entrada_pronta, if4.entrada_pronta}, 2'b00);
      chk("bp_bcd", {if5.saida_bcd, if4.saida_bcd}, {20'h00907, 16'h0907});
    end
    @(negedge clk);
    transfere();
    converte(16'd5,     20'h00005, 5'b00001, 1'b0, 16'h0005, 4'b0001, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset after the 7th shift aborts the conversion.
    @(negedge clk);
    drive(1'b1, 16'd65535, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1);
    repeat (7) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_pronta", {if5.entrada_pronta, if4.entrada_pronta}, 2'b11);
    chk("abort_valida", {if5.saida_valida, if4.saida_valida}, 2'b00);
    chk("abort_bcd", {if5.saida_bcd, if4.saida_bcd}, 36'h0);
    chk("abort_flags", {if5.saida_estouro, if4.saida_estouro, if5.saida_negativa}, 3'b000);
    chk("abort_ativo", {if5.digito_ativo, if4.digito_ativo}, {5'b00001, 4'b0001});
    chk("abort_estado", {dbg5, dbg4}, {OCIOSO, OCIOSO});
    repeat (3) @(posedge clk); #1;
    chk("abort_sem_saida", {if5.saida_valida, if4.saida_valida}, 2'b00);
    @(negedge clk); reset_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    converte(16'd42,    20'h00042, 5'b00011, 1'b0, 16'h0042, 4'b0011, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
